mem_axi_bridge: RTL



---
 rtl/mem_axi_bridge.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: turns a single-outstanding memory-stage request pulse into
// one AXI4-Lite master transaction and returns a one-cycle completion pulse.
// Every output is a register, so no AXI input reaches an output combinationally.
module mem_axi_bridge #(
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        response_enable,
  output logic [31:0] data,
  output logic        bus_error,
  output logic        busy,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] W_ADDR_DATA = 3'd1;
  localparam logic [2:0] W_RESP      = 3'd2;
  localparam logic [2:0] R_ADDR      = 3'd3;
  localparam logic [2:0] R_DATA      = 3'd4;
  localparam logic [2:0] DONE        = 3'd5;

  logic [2:0] state;

  // Each write channel is finished once its valid is low or is handshaking now.
  logic aw_done, w_done;
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  // Transaction sequencer; the payload registers double as the request latch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      response_enable <= 1'b0;
      data            <= '0;
      bus_error       <= 1'b0;
      busy            <= 1'b0;
      m_axi_awaddr    <= '0;
      m_axi_awprot    <= '0;
      m_axi_awvalid   <= 1'b0;
      m_axi_wdata     <= '0;
      m_axi_wstrb     <= '0;
      m_axi_wvalid    <= 1'b0;
      m_axi_bready    <= 1'b0;
      m_axi_araddr    <= '0;
      m_axi_arprot    <= '0;
      m_axi_arvalid   <= 1'b0;
      m_axi_rready    <= 1'b0;
    end else begin
      response_enable <= 1'b0;
      bus_error       <= 1'b0;
      case (state)
        IDLE: begin
          if (request_enable) begin
            busy         <= 1'b1;
            m_axi_awaddr <= addr;
            m_axi_araddr <= addr;
            m_axi_wdata  <= wdata;
            m_axi_wstrb  <= wstrb;
            m_axi_awprot <= PROT;
            m_axi_arprot <= PROT;
            if (mode) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= W_ADDR_DATA;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= R_ADDR;
            end
          end
        end
        W_ADDR_DATA: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axi_bvalid) begin
            bus_error       <= |m_axi_bresp;
            m_axi_bready    <= 1'b0;
            response_enable <= 1'b1;
            state           <= DONE;
          end
        end
        R_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi_rvalid) begin
            data            <= m_axi_rdata;
            bus_error       <= |m_axi_rresp;
            m_axi_rready    <= 1'b0;
            response_enable <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
